// File: rtl/proj_minhash_tracker_if.sv
// Stream/result bundle between the k-mer shift buffer, the minhash tracker and
// the sketch collector.
//   master : producer side (drives k-mers and control, consumes the result)
//   slave  : tracker side (consumes k-mers, drives in_ready/result/overrun)
// Signals:
//   kmer        k-mer, element 0 is the newest symbol
//   kmer_valid  buffer full; kmer is valid this cycle
//   start_over  synchronous clear
//   seq_end     last k-mer of the sequence
//   in_ready    tracker accepting k-mers
//   min_hash    minimum hash of the sequence
//   kmer_count  k-mers hashed in the sequence
//   out_valid   result valid
//   out_ready   downstream accept
//   overrun     sticky: input arrived while in_ready was low
interface proj_minhash_tracker_if #(
  parameter int unsigned DATA_BITS = 2,
  parameter int unsigned KMER_LEN  = 16,
  parameter int unsigned CNT_BITS  = 16
);
  localparam int unsigned OUT_KMER = KMER_LEN * DATA_BITS;

  logic [KMER_LEN-1:0][DATA_BITS-1:0] kmer;
  logic                               kmer_valid;
  logic                               start_over;
  logic                               seq_end;
  logic                               in_ready;
  logic [OUT_KMER-1:0]                min_hash;
  logic [CNT_BITS-1:0]                kmer_count;
  logic                               out_valid;
  logic                               out_ready;
  logic                               overrun;

  modport master (
    output kmer, kmer_valid, start_over, seq_end, out_ready,
    input  in_ready, min_hash, kmer_count, out_valid, overrun
  );

  modport slave (
    input  kmer, kmer_valid, start_over, seq_end, out_ready,
    output in_ready, min_hash, kmer_count, out_valid, overrun
  );
endinterface

// File: rtl/proj_minhash_tracker.sv
// Minhash tracker: hashes every k-mer presented while the shift buffer is full
// through a 2-stage multiplicative hash, tracks the minimum hash and k-mer count
// of the current sequence, and on seq_end drains the pipeline and offers
// {min_hash, kmer_count} over a valid/ready handshake.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    proj_minhash_tracker_if.slave (k-mer input, control, result, overrun)
// Optional build macro:
//   PROJ_MINHASH_CANONICAL_EN  hash min(forward, reverse-complement) instead of
//                              the forward k-mer only; latency is unchanged.
module proj_minhash_tracker #(
  parameter int unsigned         DATA_BITS = 2,
  parameter int unsigned         KMER_LEN  = 16,
  parameter int unsigned         OUT_KMER  = KMER_LEN * DATA_BITS,
  parameter logic [OUT_KMER-1:0] HASH_SEED = '0,
  parameter logic [OUT_KMER-1:0] HASH_MULT = OUT_KMER'(32'h9E37_79B1),
  parameter int unsigned         CNT_BITS  = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  proj_minhash_tracker_if.slave bus
);

  typedef enum logic [1:0] {StAccum, StDrain, StOutput} state_e;

  state_e              state_q, state_d;
  logic                s1_valid_q, s1_valid_d;
  logic [OUT_KMER-1:0] s1_q, s1_d;
  logic                s2_valid_q, s2_valid_d;
  logic [OUT_KMER-1:0] h_q, h_d;
  logic [OUT_KMER-1:0] min_q, min_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [OUT_KMER-1:0] min_hash_q, min_hash_d;
  logic [CNT_BITS-1:0] kmer_count_q, kmer_count_d;
  logic                out_valid_q, out_valid_d;
  logic                overrun_q, overrun_d;

  logic [OUT_KMER-1:0] fwd;
  logic [OUT_KMER-1:0] sel;
  logic [OUT_KMER-1:0] prod;
  logic                accept;

  assign fwd = bus.kmer;

`ifdef PROJ_MINHASH_CANONICAL_EN
  logic [KMER_LEN-1:0][DATA_BITS-1:0] rc;

  // Reverse symbol order and complement each symbol (A<->T, C<->G).
  always_comb begin
    for (int unsigned i = 0; i < KMER_LEN; i++) begin
      rc[i] = ~bus.kmer[KMER_LEN-1-i];
    end
  end

  assign sel = (OUT_KMER'(rc) < fwd) ? OUT_KMER'(rc) : fwd;
`else
  assign sel = fwd;
`endif

  // Product truncated to OUT_KMER bits (mod 2^OUT_KMER).
  assign prod   = s1_q * HASH_MULT;
  assign accept = (state_q == StAccum) && bus.kmer_valid;

  always_comb begin
    state_d      = state_q;
    s1_valid_d   = accept;
    s1_d         = s1_q;
    s2_valid_d   = s1_valid_q;
    h_d          = h_q;
    min_d        = min_q;
    count_d      = count_q;
    min_hash_d   = min_hash_q;
    kmer_count_d = kmer_count_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;

    if (accept) begin
      s1_d = sel ^ HASH_SEED;
    end
    if (s1_valid_q) begin
      h_d = prod ^ (prod >> (OUT_KMER / 2));
    end
    if (s2_valid_q) begin
      if (h_q < min_q) begin
        min_d = h_q;
      end
      if (count_q != '1) begin
        count_d = count_q + CNT_BITS'(1);
      end
    end

    if ((state_q != StAccum) && (bus.kmer_valid || bus.seq_end)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StAccum: begin
        if (bus.seq_end) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Both stages empty means the last min/count update has landed.
        if (!s1_valid_q && !s2_valid_q) begin
          min_hash_d   = min_q;
          kmer_count_d = count_q;
          out_valid_d  = 1'b1;
          state_d      = StOutput;
        end
      end
      StOutput: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          min_d       = '1;
          count_d     = '0;
          state_d     = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase

    // start_over wins over everything else this cycle.
    if (bus.start_over) begin
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      min_d       = '1;
      count_d     = '0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
      state_d     = StAccum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StAccum;
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      h_q          <= '0;
      min_q        <= '1;
      count_q      <= '0;
      min_hash_q   <= '0;
      kmer_count_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      h_q          <= h_d;
      min_q        <= min_d;
      count_q      <= count_d;
      min_hash_q   <= min_hash_d;
      kmer_count_q <= kmer_count_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.in_ready   = (state_q == StAccum);
  assign bus.min_hash   = min_hash_q;
  assign bus.kmer_count = kmer_count_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_proj_minhash_tracker.sv
// Scoreboard bench for proj_minhash_tracker with default parameters.
module tb_proj_minhash_tracker;

  localparam longint unsigned Mult = 64'h9E37_79B1;
  localparam longint unsigned Seed = 64'h0;

  logic clk;
  logic rst_n;

  proj_minhash_tracker_if #(.DATA_BITS(2), .KMER_LEN(16), .CNT_BITS(16)) bus ();

  proj_minhash_tracker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;  // 0: out_ready low, 1: high, 2: random

  logic [47:0] exp_q[$];  // {min_hash, kmer_count}
  logic [31:0] m_min;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference hash straight from the arithmetic definition.
  function automatic logic [31:0] model_hash(input logic [31:0] k);
    longint unsigned x, p;
    logic [31:0] rc;
    for (int i = 0; i < 16; i++) rc[2*i +: 2] = ~k[2*(15-i) +: 2];
`ifdef PROJ_MINHASH_CANONICAL_EN
    x = (rc < k) ? longint'(rc) : longint'(k);
`else
    x = longint'(k);
`endif
    x = x ^ Seed;
    p = (x * Mult) % 64'h1_0000_0000;
    return 32'(p ^ (p >> 16));
  endfunction

  function automatic void model_clear();
    m_min = 32'hFFFF_FFFF;
    m_cnt = 0;
  endfunction

  function automatic void model_kmer(input logic [31:0] k);
    logic [31:0] h;
    h = model_hash(k);
    if (h < m_min) m_min = h;
    if (m_cnt < 65535) m_cnt++;
  endfunction

  function automatic void model_end();
    exp_q.push_back({m_min, 16'(m_cnt)});
    model_clear();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.kmer       = '0;
    bus.kmer_valid = 1'b0;
    bus.seq_end    = 1'b0;
    bus.start_over = 1'b0;
  endtask

  task automatic send_kmer(input logic [31:0] k, input bit last);
    bus.kmer       = k;
    bus.kmer_valid = 1'b1;
    bus.seq_end    = last;
    model_kmer(k);
    if (last) model_end();
    step();
    idle_inputs();
  endtask

  task automatic send_rand(input int n, input bit gaps);
    if (n == 0) begin
      bus.seq_end = 1'b1;
      model_end();
      step();
      idle_inputs();
    end else begin
      for (int i = 0; i < n; i++) begin
        if (gaps && ($urandom_range(0, 2) == 0)) step();
        send_kmer($urandom, i == n - 1);
      end
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready && t < 300) begin
      step();
      t++;
    end
    if (!bus.in_ready) check("in_ready timeout", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic wait_out_valid();
    int t = 0;
    while (!bus.out_valid && t < 100) begin
      step();
      t++;
    end
    if (!bus.out_valid) check("out_valid timeout", 64'(bus.out_valid), 64'd1);
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      step();
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare each accepted result with the scoreboard.
  initial begin
    bit hs_prev = 1'b0;
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hs_prev) check("in_ready after handshake", 64'(bus.in_ready), 64'd1);
        hs_prev = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          hs_prev = 1'b1;
          if (exp_q.size() == 0) begin
            check("unexpected result", 64'(bus.out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("min_hash", 64'(bus.min_hash), 64'(e[47:16]));
            check("kmer_count", 64'(bus.kmer_count), 64'(e[15:0]));
          end
        end
      end else begin
        hs_prev = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] e;
    int t;
    model_clear();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset overrun", 64'(bus.overrun), 64'd0);
    check("reset min_hash", 64'(bus.min_hash), 64'd0);
    check("reset kmer_count", 64'(bus.kmer_count), 64'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("in_ready after reset", 64'(bus.in_ready), 64'd1);

    // Three k-mers, result held while out_ready is low, then an overrun.
    rdy_mode = 0;
    send_kmer(32'd5, 1'b0);
    send_kmer(32'd3, 1'b0);
    send_kmer(32'd9, 1'b1);
    check("in_ready low in drain", 64'(bus.in_ready), 64'd0);
    wait_out_valid();
    e = (exp_q.size() > 0) ? exp_q[0] : 48'h0;
    for (int i = 0; i < 4; i++) begin
      check("held out_valid", 64'(bus.out_valid), 64'd1);
      check("held min_hash", 64'(bus.min_hash), 64'(e[47:16]));
      check("held kmer_count", 64'(bus.kmer_count), 64'(e[15:0]));
      step();
    end
    bus.kmer       = $urandom;
    bus.kmer_valid = 1'b1;
    step();
    idle_inputs();
    step();
    check("overrun set", 64'(bus.overrun), 64'd1);
    check("kmer_count unchanged", 64'(bus.kmer_count), 64'(e[15:0]));
    rdy_mode = 1;
    wait_ready();

    // Boundary k-mers and an empty sequence.
    send_kmer(32'h0000_0000, 1'b1);
    wait_ready();
    send_kmer(32'hFFFF_FFFF, 1'b1);
    wait_ready();
    send_rand(0, 1'b0);
    wait_ready();

    // start_over with seq_end while a result is pending: result discarded.
    rdy_mode = 0;
    send_rand(4, 1'b0);
    wait_out_valid();
    bus.kmer_valid = 1'b1;
    step();
    idle_inputs();
    bus.start_over = 1'b1;
    bus.seq_end    = 1'b1;
    void'(exp_q.pop_back());
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check("start_over out_valid", 64'(bus.out_valid), 64'd0);
      check("start_over overrun", 64'(bus.overrun), 64'd0);
      check("start_over in_ready", 64'(bus.in_ready), 64'd1);
      step();
    end

    // start_over mid-sequence drops the partial sequence.
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      bus.kmer       = $urandom;
      bus.kmer_valid = 1'b1;
      step();
    end
    bus.start_over = 1'b1;
    step();
    idle_inputs();
    model_clear();
    send_rand(2, 1'b0);
    wait_ready();

    // Back-to-back 20 k-mers.
    send_rand(20, 1'b0);
    wait_ready();

    // Random sequences with gaps and random back-pressure.
    rdy_mode = 2;
    for (int s = 0; s < 15; s++) begin
      send_rand($urandom_range(0, 12), 1'b1);
      wait_ready();
    end

    // Asynchronous reset while a result is pending.
    rdy_mode = 0;
    send_rand(5, 1'b0);
    wait_out_valid();
    #3;
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 64'(bus.out_valid), 64'd0);
    check("mid reset overrun", 64'(bus.overrun), 64'd0);
    check("mid reset min_hash", 64'(bus.min_hash), 64'd0);
    check("mid reset kmer_count", 64'(bus.kmer_count), 64'd0);
    exp_q.delete();
    model_clear();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("in_ready after mid reset", 64'(bus.in_ready), 64'd1);
    rdy_mode = 1;
    send_rand(6, 1'b1);
    wait_ready();

    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      step();
      t++;
    end
    if (exp_q.size() > 0) check("results outstanding", 64'(exp_q.size()), 64'd0);
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/proj_minhash_tracker.md
Name: proj_minhash_tracker

Overview:
Downstream consumer of the k-mer shift buffer. Each cycle the buffer reports full, this block hashes the presented k-mer through a 2-stage pipeline and tracks the minimum hash over the current sequence. On end-of-sequence it drains the pipeline and emits the minimum hash and k-mer count over a valid/ready handshake to the sketch collector.

Parameters:
DATA_BITS, 2, bits per nucleotide symbol (A=00, C=01, G=10, T=11)
KMER_LEN, 16, symbols per k-mer
OUT_KMER, KMER_LEN*DATA_BITS, flattened k-mer width; also the hash width
HASH_SEED, 32'h0000_0000, XOR seed applied before multiply
HASH_MULT, 32'h9E37_79B1, odd multiplier
CNT_BITS, 16, k-mer counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
kmer  in  [KMER_LEN-1:0][DATA_BITS-1:0]  k-mer from the buffer; element 0 is the newest symbol
kmer_valid  in  1  buffer full flag; k-mer is valid this cycle
start_over  in  1  sync clear; aligned with the buffer's start_over
seq_end  in  1  single-cycle pulse marking the last k-mer of the sequence
in_ready  out  1  high in ACCUM; k-mers presented while low are dropped
min_hash  out  OUT_KMER  minimum hash of the sequence
kmer_count  out  CNT_BITS  k-mers hashed in the sequence
out_valid  out  1  result valid
out_ready  in  1  downstream accept
overrun  out  1  sticky: a k-mer or seq_end arrived while in_ready=0

Behaviour:
- Reset (asynchronous, active-low): state=ACCUM; pipeline valids=0; min register=all ones; count=0; out_valid=0; overrun=0; min_hash=0; kmer_count=0; in_ready=1 once reset releases.
- Hash: x = flat(kmer) ^ HASH_SEED (stage 1 register). p = (x * HASH_MULT) mod 2^OUT_KMER. h = p ^ (p >> OUT_KMER/2) (stage 2 register).
- Update: cycle N kmer_valid & in_ready -> s1 at N+1 -> h at N+2 -> min/count updated at the N+3 edge. min = (h < min) ? h : min, unsigned compare. count saturates at all ones.
- States:
  - ACCUM: accept k-mers. On seq_end, go to DRAIN. If kmer_valid is high in the same cycle, that k-mer is included.
  - DRAIN: in_ready=0. When both pipeline valids and any pending update have retired, latch min/count to the outputs, set out_valid=1, go to OUTPUT.
  - OUTPUT: hold min_hash/kmer_count/out_valid stable until out_ready is sampled high. Then out_valid=0, min=all ones, count=0, go to ACCUM (in_ready=1 the next cycle).
- Empty sequence (seq_end with no k-mers): emit min_hash=all ones, kmer_count=0.
- out_ready high while out_valid low: ignored.
- kmer_valid or seq_end while in DRAIN/OUTPUT: ignored and sets overrun.
- start_over (any state): next cycle clears pipeline valids, min=all ones, count=0, out_valid=0, overrun=0, state=ACCUM. It has priority over seq_end, kmer_valid and out_ready in the same cycle; any pending result is discarded.

Optional Feature:
PROJ_MINHASH_CANONICAL_EN: when defined, stage 1 hashes the canonical k-mer, min(flat(kmer), flat(revcomp(kmer))), unsigned. revcomp reverses symbol order and bitwise-inverts each symbol (A<->T, C<->G). The extra mux stays inside stage 1, so latency is unchanged. When undefined, only the forward k-mer is hashed.

Test Plan:
- Reset then idle: rst_n low mid-operation -> in the same cycle out_valid=0, overrun=0, min_hash=0, kmer_count=0; in_ready=1 once rst_n returns high.
- HASH_MULT=1, SEED=0; k-mers 5, 3, 9 on consecutive cycles, seq_end with the last -> out_valid rises after drain with min_hash=3, kmer_count=3; held 4 cycles with out_ready=0, then accepted.
- Default params; single all-zero k-mer + seq_end -> min_hash=0, kmer_count=1. Then a seq_end alone -> min_hash=32'hFFFF_FFFF, kmer_count=0.
- k-mer presented during OUTPUT -> overrun=1, count unchanged. start_over with seq_end in the same cycle -> out_valid stays 0, overrun=0, next sequence starts from min=all ones.
- CANONICAL_EN, MULT=1, SEED=0: k-mer all T (32'hFFFF_FFFF) -> revcomp=0, min_hash=0. Disabled: same stimulus -> min_hash=32'hFFFF_0000 (p ^ p>>16).
- Back-to-back: 20 k-mers, seq_end, out_ready tied high -> kmer_count=20; ACCUM resumes with in_ready=1 the cycle after the handshake.
